// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: widths, PC step and queue entry type shared by the fetch unit and its queue.
package fetch_pkg;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: synchronous FIFO of fetch entries; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Entries are cleared on reset so the head reads as zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: PC generation with credit-based issue into a registered icache,
// responses queued for decode; redirect flushes everything in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 9'h000,
  parameter int              FQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    icache_addr,
  input  logic [INSTR_W-1:0] icache_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   fq_count;
  logic [CW:0]     credit_used;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // A pop in the same cycle earns no credit, keeping the check off the ready path.
  assign credit_used = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
  assign issue       = !redirect_valid && (credit_used < (CW+1)'(FQ_DEPTH));
  assign push        = inflight && !redirect_valid;
  assign pop         = out_valid && out_ready;

  assign icache_addr = pc_q;
  assign out_valid   = (fq_count != '0);
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = icache_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc_q     <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc_q        <= pc_q + PC_W'(PC_STEP);
      inflight    <= 1'b1;
      inflight_pc <= pc_q;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .count (fq_count),
    .head  (head)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fetch_unit: directed scenarios plus randomized ready/redirect traffic against a stream-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [8:0]  icache_addr, icache_addr2;
  logic [31:0] icache_instr, icache_instr2;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_instr, out_instr2;
  logic [8:0]  out_pc, out_pc2;

  int          checks   = 0;
  int          errors   = 0;
  int          accepted = 0;
  logic [8:0]  exp_pc;
  logic [8:0]  exp2;

  // Registered instruction caches holding word[i] = i.
  always @(posedge clk) icache_instr  <= {25'd0, icache_addr[8:2]};
  always @(posedge clk) icache_instr2 <= {25'd0, icache_addr2[8:2]};

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_instr   (icache_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  fetch_unit #(
    .RESET_PC (9'h1F8)
  ) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr2),
    .icache_instr   (icache_instr2),
    .redirect_valid (1'b0),
    .redirect_pc    (9'h000),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic: head must always be the next expected instruction.
  task automatic cycle(input logic rdy, input logic rv, input logic [8:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (out_valid) begin
      check("head_pc", {23'd0, out_pc}, {23'd0, exp_pc});
      check("head_instr", out_instr, {25'd0, exp_pc[8:2]});
      if (rdy) begin
        exp_pc = exp_pc + 9'd4;
        accepted++;
      end
    end
    if (rv) exp_pc = {rpc[8:2], 2'b00};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_hold;
    logic prev_redir;
    logic rdy, rv;
    logic [8:0] rpc;
    int   acc_start;

    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", {23'd0, out_pc}, 32'd0);
    check("rst_addr", {23'd0, icache_addr}, 32'd0);
    check("rst_addr_wrap", {23'd0, icache_addr2}, 32'h1F8);

    // Release: out_valid two cycles later, then one instruction per cycle.
    reset  = 1'b1;
    exp_pc = 9'h000;
    exp2   = 9'h1F8;
    check("start_valid0", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 1'b0, 9'h0);
    check("start_valid1", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 1'b0, 9'h0);
    check("start_valid2", {31'd0, out_valid}, 32'd1);
    check("start_pc", {23'd0, out_pc}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("stream_nogap", {31'd0, out_valid}, 32'd1);
      check("wrap_valid", {31'd0, out_valid2}, 32'd1);
      check("wrap_pc", {23'd0, out_pc2}, {23'd0, exp2});
      check("wrap_instr", out_instr2, {25'd0, exp2[8:2]});
      exp2 = exp2 + 9'd4;
      cycle(1'b1, 1'b0, 9'h0);
    end

    // Backpressure: queue fills, head holds, issue stops four words ahead.
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      cycle(1'b0, 1'b0, 9'h0);
    end
    check("stall_addr", {23'd0, icache_addr}, {23'd0, exp_pc + 9'd16});
    for (int i = 0; i < 8; i++) begin
      check("drain_nogap", {31'd0, out_valid}, 32'd1);
      cycle(1'b1, 1'b0, 9'h0);
    end

    // Redirect with three queued entries.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 9'h0);
    cycle(1'b1, 1'b0, 9'h0);
    cycle(1'b0, 1'b1, 9'h043);
    check("redir_valid_t1", {31'd0, out_valid}, 32'd0);
    check("redir_addr_t1", {23'd0, icache_addr}, 32'h040);
    cycle(1'b0, 1'b0, 9'h0);
    check("redir_valid_t2", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 1'b0, 9'h0);
    check("redir_valid_t3", {31'd0, out_valid}, 32'd1);
    check("redir_pc_t3", {23'd0, out_pc}, 32'h040);
    cycle(1'b0, 1'b0, 9'h0);

    // Asynchronous reset mid-stream with two entries queued.
    #2 reset = 1'b0;
    #1;
    check("areset_valid", {31'd0, out_valid}, 32'd0);
    check("areset_addr", {23'd0, icache_addr}, 32'd0);
    check("areset_pc", {23'd0, out_pc}, 32'd0);
    check("areset_instr", out_instr, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset  = 1'b1;
    exp_pc = 9'h000;
    cycle(1'b1, 1'b0, 9'h0);
    check("restart_valid1", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 1'b0, 9'h0);
    check("restart_valid2", {31'd0, out_valid}, 32'd1);
    check("restart_pc", {23'd0, out_pc}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("restart_nogap", {31'd0, out_valid}, 32'd1);
      cycle(1'b1, 1'b0, 9'h0);
    end

    // Random ready and redirect traffic.
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    acc_start  = accepted;
    for (int i = 0; i < 300; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = 9'($urandom);
      if (prev_hold) check("rand_hold_valid", {31'd0, out_valid}, 32'd1);
      if (prev_redir) check("rand_flush_valid", {31'd0, out_valid}, 32'd0);
      prev_hold  = out_valid && !rdy && !rv;
      prev_redir = rv;
      cycle(rdy, rv, rpc);
    end
    check("rand_throughput", {31'd0, (accepted - acc_start) > 80}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
